// File: rtl/pbtn_event.sv
// Push-button event generator: press/release/auto-repeat pulses from debounced
// levels, plus sticky per-button event and overrun flags with a masked clear.
module pbtn_event #(
    parameter int WIDTH         = 6,
    parameter int HOLD_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 10_000_000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pbtn_db,
    input  logic             clr_strobe,
    input  logic [WIDTH-1:0] clr_mask,
    output logic [WIDTH-1:0] press_pulse,
    output logic [WIDTH-1:0] release_pulse,
    output logic [WIDTH-1:0] repeat_pulse,
    output logic [WIDTH-1:0] event_flags,
    output logic [WIDTH-1:0] overrun,
    output logic             irq
);

    localparam int MAX_CYCLES = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);
    localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;

    state_t            state [WIDTH];
    logic [CW-1:0]     cnt   [WIDTH];
    logic [WIDTH-1:0]  db_q;
    logic [WIDTH-1:0]  lvl_q;
    logic [WIDTH-1:0]  press;
    logic [WIDTH-1:0]  rel;
    logic [WIDTH-1:0]  set_evt;
    logic [WIDTH-1:0]  clr_evt;

    // db_q adds one input stage so a pulse appears in the cycle after the
    // second edge following a level change.
    always_comb begin
        press = db_q & ~lvl_q;
        rel   = ~db_q & lvl_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            db_q          <= pbtn_db;
            lvl_q         <= pbtn_db;
            press_pulse   <= '0;
            release_pulse <= '0;
            repeat_pulse  <= '0;
            for (int unsigned i = 0; i < int'(WIDTH); i++) begin
                state[i] <= IDLE;
                cnt[i]   <= '0;
            end
        end else begin
            db_q          <= pbtn_db;
            lvl_q         <= db_q;
            press_pulse   <= press;
            release_pulse <= rel;
            repeat_pulse  <= '0;
            for (int unsigned i = 0; i < int'(WIDTH); i++) begin
                case (state[i])
                    IDLE: begin
                        if (press[i]) begin
                            state[i] <= HOLD;
                            cnt[i]   <= '0;
                        end
                    end
                    HOLD: begin
                        if (!db_q[i]) begin
                            state[i] <= IDLE;
                            cnt[i]   <= '0;
                        end else if (cnt[i] == HOLD_LAST) begin
                            repeat_pulse[i] <= 1'b1;
                            state[i]        <= REPEAT;
                            cnt[i]          <= '0;
                        end else begin
                            cnt[i] <= cnt[i] + CW'(1);
                        end
                    end
                    REPEAT: begin
                        if (!db_q[i]) begin
                            state[i] <= IDLE;
                            cnt[i]   <= '0;
                        end else if (cnt[i] == REPEAT_LAST) begin
                            repeat_pulse[i] <= 1'b1;
                            cnt[i]          <= '0;
                        end else begin
                            cnt[i] <= cnt[i] + CW'(1);
                        end
                    end
                    default: begin
                        state[i] <= IDLE;
                        cnt[i]   <= '0;
                    end
                endcase
            end
        end
    end

    always_comb begin
        set_evt = press_pulse | repeat_pulse;
        clr_evt = clr_mask & {WIDTH{clr_strobe}};
    end

    // Set beats clear; a clear in the same cycle consumes the old flag, so no overrun.
    always_ff @(posedge clk) begin
        if (reset) begin
            event_flags <= '0;
            overrun     <= '0;
        end else begin
            event_flags <= (event_flags & ~clr_evt) | set_evt;
            overrun     <= (overrun & ~clr_evt) | (set_evt & event_flags & ~clr_evt);
        end
    end

    assign irq = |event_flags;

endmodule

// File: tb/tb_pbtn_event.sv
// Directed bench for pbtn_event with HOLD_CYCLES=8, REPEAT_CYCLES=4, WIDTH=6.
module tb_pbtn_event;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] pbtn_db;
    logic       clr_strobe;
    logic [5:0] clr_mask;
    logic [5:0] press_pulse;
    logic [5:0] release_pulse;
    logic [5:0] repeat_pulse;
    logic [5:0] event_flags;
    logic [5:0] overrun;
    logic       irq;

    int n_checks = 0;
    int n_pass   = 0;

    pbtn_event #(
        .WIDTH        (6),
        .HOLD_CYCLES  (8),
        .REPEAT_CYCLES(4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pbtn_db      (pbtn_db),
        .clr_strobe   (clr_strobe),
        .clr_mask     (clr_mask),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .repeat_pulse (repeat_pulse),
        .event_flags  (event_flags),
        .overrun      (overrun),
        .irq          (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_all();
        clr_strobe = 1'b1;
        clr_mask   = 6'h3f;
        step();
        clr_strobe = 1'b0;
        clr_mask   = '0;
    endtask

    initial begin
        logic [4:0] exp_v;
        reset      = 1'b1;
        pbtn_db    = 6'b000001;
        clr_strobe = 1'b0;
        clr_mask   = '0;

        // Reset with a button held
        repeat (3) step();
        check("rst_outs", {press_pulse, release_pulse, repeat_pulse, event_flags, overrun}, '0);
        check("rst_irq", irq, 0);
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            check("rst_nopress", {press_pulse, event_flags, irq}, '0);
        end
        pbtn_db = '0;
        repeat (4) step();

        // Single tap on button 2
        pbtn_db = 6'b000100;
        step();
        step();
        check("tap_press", press_pulse, 6'b000100);
        step();
        check("tap_press_end", press_pulse, 0);
        check("tap_flags", event_flags, 6'b000100);
        check("tap_irq", irq, 1);
        pbtn_db = '0;
        step();
        check("tap_norel_early", release_pulse, 0);
        step();
        check("tap_release", release_pulse, 6'b000100);
        step();
        check("tap_release_end", release_pulse, 0);
        repeat (10) begin
            step();
            check("tap_norepeat", repeat_pulse, 0);
        end
        clear_all();
        check("tap_cleared", {event_flags, irq}, 0);

        // Hold button 0 for 20 cycles: press n=1, repeats n=9,13,17, release n=21
        pbtn_db = 6'b000001;
        for (int n = 0; n < 25; n++) begin
            step();
            exp_v[4] = (n == 1);
            exp_v[3] = (n == 9) || (n == 13) || (n == 17);
            exp_v[2] = (n == 21);
            exp_v[1] = (n >= 2);
            exp_v[0] = (n >= 10);
            check($sformatf("hold_n%0d", n),
                  {press_pulse[0], repeat_pulse[0], release_pulse[0], event_flags[0], overrun[0]},
                  exp_v);
            if (n == 19) pbtn_db = '0;
        end

        // Clear handshake
        pbtn_db = 6'b000010;
        step();
        step();
        step();
        check("clr_pre_flags", event_flags, 6'b000011);
        check("clr_pre_ovr", overrun, 6'b000001);
        clr_strobe = 1'b1;
        clr_mask   = 6'b000001;
        step();
        clr_strobe = 1'b0;
        clr_mask   = '0;
        check("clr_flags", event_flags, 6'b000010);
        check("clr_ovr", overrun, 0);
        pbtn_db = '0;
        repeat (4) step();
        pbtn_db = 6'b000010;
        step();
        step();
        check("clr_race_press", press_pulse, 6'b000010);
        clr_strobe = 1'b1;
        clr_mask   = 6'b000010;
        step();
        clr_strobe = 1'b0;
        clr_mask   = '0;
        check("clr_race_flag", event_flags, 6'b000010);
        check("clr_race_ovr", overrun, 0);
        pbtn_db = '0;
        repeat (4) step();
        clr_strobe = 1'b1;
        clr_mask   = '0;
        step();
        clr_strobe = 1'b0;
        check("clr_zero_mask", event_flags, 6'b000010);
        clear_all();
        check("clr_all", {event_flags, overrun, irq}, 0);

        // All buttons at once
        pbtn_db = 6'h3f;
        step();
        step();
        check("all_press", press_pulse, 6'h3f);
        step();
        check("all_press_end", press_pulse, 0);
        check("all_flags", event_flags, 6'h3f);
        pbtn_db = '0;
        step();
        step();
        check("all_release", release_pulse, 6'h3f);
        step();
        check("all_release_end", release_pulse, 0);
        clear_all();

        // Reset during repeat with the button still held
        pbtn_db = 6'b000001;
        repeat (10) step();
        check("mid_repeat_seen", repeat_pulse, 6'b000001);
        reset = 1'b1;
        step();
        check("mid_rst_outs", {press_pulse, release_pulse, repeat_pulse, event_flags, overrun}, '0);
        check("mid_rst_irq", irq, 0);
        reset = 1'b0;
        for (int c = 0; c < 15; c++) begin
            step();
            check("mid_rst_quiet", {press_pulse, repeat_pulse, release_pulse, event_flags}, '0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
